// File: rtl/dual_port_memory_if.sv
// Bus bundle for dual_port_memory: clear control, port A (read/write)
// and port B (read-only). The memory itself takes the slave view.
interface dual_port_memory_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  Clear_req;
    logic                  Busy;

    logic [ADDR_WIDTH-1:0] A_addr;
    logic [DATA_WIDTH-1:0] A_data_in;
    logic                  A_write;
    logic                  A_read;
    logic [DATA_WIDTH-1:0] A_data_out;
    logic                  A_valid;
    logic                  A_err;

    logic [ADDR_WIDTH-1:0] B_addr;
    logic                  B_read;
    logic [DATA_WIDTH-1:0] B_data_out;
    logic                  B_valid;

    modport master (
        output Clear_req, A_addr, A_data_in, A_write, A_read, B_addr, B_read,
        input  Busy, A_data_out, A_valid, A_err, B_data_out, B_valid
    );

    modport slave (
        input  Clear_req, A_addr, A_data_in, A_write, A_read, B_addr, B_read,
        output Busy, A_data_out, A_valid, A_err, B_data_out, B_valid
    );
endinterface

// File: rtl/dual_port_memory.sv
// Dual-port data memory: port A read/write, port B read-only, both with
// registered single-cycle reads, plus a clear engine that zeroes the array.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | normal access on both ports; Clear_req starts a clear
// ST_CLEAR | one word zeroed per cycle at clr_ptr; port traffic ignored
module dual_port_memory #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int DEPTH          = 256,
    parameter int READ_MODE      = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic               CLK,
    input logic               RST,
    dual_port_memory_if.slave bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int unsigned           DEPTH_U    = DEPTH;
    localparam int unsigned           LAST_U     = DEPTH - 1;
    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0]   DEPTH_W    = DEPTH_U[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST   = LAST_U[ADDR_WIDTH-1:0];
    localparam state_t                RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic                  busy;
    logic                  clr_we;

    logic                  a_in_range;
    logic                  b_in_range;
    logic                  a_wr_en;
    logic                  a_rd_en;
    logic                  b_rd_en;
    logic [DATA_WIDTH-1:0] a_rd_word;
    logic [DATA_WIDTH-1:0] b_rd_word;
    logic [DATA_WIDTH-1:0] a_rd_next;
    logic [DATA_WIDTH-1:0] b_rd_next;

    logic [DATA_WIDTH-1:0] a_data_q;
    logic [DATA_WIDTH-1:0] b_data_q;
    logic                  a_valid_q;
    logic                  b_valid_q;
    logic                  a_err_q;

    // State register; reset (re)starts a clear when CLEAR_ON_RESET is set.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; Clear_req is only honoured from idle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (bus.Clear_req) state_next = ST_CLEAR;
            ST_CLEAR: if (clr_ptr == PTR_LAST) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State outputs: busy and the clear write strobe.
    always_comb begin
        busy   = (state == ST_CLEAR);
        clr_we = (state == ST_CLEAR);
    end

    // Clear pointer: zeroed on reset or clear start, walks up while clearing.
    always_ff @(posedge CLK) begin
        if (RST) begin
            clr_ptr <= '0;
        end else if (state == ST_IDLE && bus.Clear_req) begin
            clr_ptr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
        end
    end

    assign a_in_range = ({1'b0, bus.A_addr} < DEPTH_W);
    assign b_in_range = ({1'b0, bus.B_addr} < DEPTH_W);
    assign a_wr_en    = bus.A_write && !busy && a_in_range;
    assign a_rd_en    = bus.A_read && !busy;
    assign b_rd_en    = bus.B_read && !busy;
    assign a_rd_word  = mem[bus.A_addr];
    assign b_rd_word  = mem[bus.B_addr];

    // Read data selection: out-of-range reads give 0; in write-first mode a
    // same-address write bypasses the array.
    always_comb begin
        a_rd_next = '0;
        b_rd_next = '0;
        if (a_in_range) begin
            if (READ_MODE == 1 && a_wr_en) a_rd_next = bus.A_data_in;
            else                           a_rd_next = a_rd_word;
        end
        if (b_in_range) begin
            if (READ_MODE == 1 && a_wr_en && bus.B_addr == bus.A_addr) b_rd_next = bus.A_data_in;
            else                                                       b_rd_next = b_rd_word;
        end
    end

    // Array write port: the clear engine owns the array while busy.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (clr_we) begin
                mem[clr_ptr] <= '0;
            end else if (a_wr_en) begin
                mem[bus.A_addr] <= bus.A_data_in;
            end
        end
    end

    // Registered read outputs and error pulse; data holds when not read.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_data_q  <= '0;
            b_data_q  <= '0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            a_err_q   <= 1'b0;
        end else begin
            a_valid_q <= a_rd_en;
            b_valid_q <= b_rd_en;
            a_err_q   <= (bus.A_read || bus.A_write) && !busy && !a_in_range;
            if (a_rd_en) a_data_q <= a_rd_next;
            if (b_rd_en) b_data_q <= b_rd_next;
        end
    end

    assign bus.Busy       = busy;
    assign bus.A_data_out = a_data_q;
    assign bus.A_valid    = a_valid_q;
    assign bus.A_err      = a_err_q;
    assign bus.B_data_out = b_data_q;
    assign bus.B_valid    = b_valid_q;

endmodule

// File: doc/dual_port_memory.md
Name: dual_port_memory

Overview:
- Parametrised successor to the ASIP's single-port data memory.
- Port A is read/write and serves the datapath load/store. Port B is read-only and serves operand/instruction fetch.
- Both ports have registered (1-cycle) reads with valid strobes.
- A built-in clear engine zeroes the whole array on reset or on request.

Parameters:
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 8: address width in bits.
- DEPTH, 256: number of words. Must satisfy DEPTH <= 2**ADDR_WIDTH.
- READ_MODE, 0: selects what a read returns when the same address is written in the same cycle. 0 = read-first (returns the old word). 1 = write-first (returns the new word).
- CLEAR_ON_RESET, 1: 1 = reset launches a full clear. 0 = reset leaves the array contents untouched.

Ports:
- CLK  in  1  single clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- Clear_req  in  1  one-cycle pulse requesting a full-array clear.
- Busy  out  1  high while the clear engine runs.
- A_addr  in  ADDR_WIDTH  port A address.
- A_data_in  in  DATA_WIDTH  port A write data.
- A_write  in  1  port A write enable.
- A_read  in  1  port A read request.
- A_data_out  out  DATA_WIDTH  port A registered read data.
- A_valid  out  1  A_data_out is updated this cycle.
- A_err  out  1  one-cycle pulse: port A accessed with A_addr >= DEPTH.
- B_addr  in  ADDR_WIDTH  port B address.
- B_read  in  1  port B read request.
- B_data_out  out  DATA_WIDTH  port B registered read data.
- B_valid  out  1  B_data_out is updated this cycle.

Behaviour:
- Reset (RST=1 at an edge):
  - A_data_out=0, B_data_out=0, A_valid=0, B_valid=0, A_err=0.
  - Clear pointer set to 0.
  - Next state is CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
  - Busy=1 from the cycle after reset when entering CLEAR.
  - Reset has priority over all other inputs. Reset during CLEAR restarts the clear from address 0.
- FSM states:
  - IDLE: normal access. Clear_req=1 -> CLEAR; the pointer loads 0.
  - CLEAR: writes 0 to the pointer address, increments the pointer, and keeps Busy=1. After writing DEPTH-1 -> IDLE; Busy falls in the first IDLE cycle.
  - A clear takes exactly DEPTH cycles. Clear_req during CLEAR is ignored (no restart).
- While Busy=1:
  - A_write is dropped.
  - A_read and B_read are ignored; A_valid and B_valid stay 0 and the data outputs hold their values.
- Read latency: a request sampled at edge N gives data and valid=1 after edge N, for one cycle. With no request, valid=0 and the data output holds its last value.
- Writes: A_write=1 stores A_data_in at A_addr on the edge.
- Same-cycle collisions (A_write with A_read, or with B_read, on the same address):
  - READ_MODE=0: returns the pre-write word.
  - READ_MODE=1: returns A_data_in.
  - Different addresses: the ports are fully independent.
- Out-of-range address (only possible when DEPTH < 2**ADDR_WIDTH):
  - Port A: the write is dropped; a read returns 0 with A_valid=1.
  - A_err pulses for one cycle if A_read or A_write was set.
  - Port B: a read returns 0 with B_valid=1; no error output.
- Uninitialised contents (CLEAR_ON_RESET=0, never written) are don't-care. The bench must not check them.

Test Plan:
1. Reset clear:
   - Stimulus: RST for 1 cycle, DEPTH=256.
   - Response: Busy=1 for exactly 256 cycles, then 0. A_read at addresses 0, 17, 255 returns 0 with A_valid one cycle later.
2. Write then read:
   - Stimulus: A_write addr 16 data 6, next cycle A_read 16 and B_read 16.
   - Response: both A_data_out and B_data_out =6 with valid=1, one cycle after the request.
3. Collision:
   - Stimulus: addr 5 holds 3; same cycle A_write addr 5 data 9 and B_read addr 5.
   - Response: B_data_out=3 with READ_MODE=0, 9 with READ_MODE=1. A following read of addr 5 returns 9.
4. Clear_req mid-traffic:
   - Stimulus: write 0xAA to addr 200; pulse Clear_req; issue A_write and B_read during Busy.
   - Response: valids stay 0 and the write is dropped. After Busy falls, addr 200 reads 0.
5. Reset mid-clear:
   - Stimulus: assert RST at clear pointer 100.
   - Response: Busy stays high and the clear restarts at 0. Total busy time after the reset is 256 cycles.
6. Out of range:
   - Stimulus: DEPTH=200, A_write addr 210 data 7, then A_read 210.
   - Response: A_err pulses on both accesses, the read returns 0 with A_valid=1, and addr 10 (210 mod 200) is unchanged.
